dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters.
- Port 0 is the CPU data port; port 1 is a DMA/debug loader that can lock the memory for bursts.
- Issues at most one memory access per cycle, with round-robin fairness and a bounded lock burst.
- Routes the one-cycle-latency read data back to whichever requester issued the access.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between a CPU port and a lockable DMA/debug port
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_d,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_d,
    input  logic [3:0]  m1_we,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_d,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_q
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    logic             last;
    logic             locked;
    logic             locked_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic             r_owner0;
    logic             r_owner1;
    logic             sel0;
    logic             sel1;
    // choose the port that owns the memory this cycle: lock burst, forced yield, round-robin, single requester
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
        if (locked && m1_req) begin
            sel1 = !m0_req || (burst_cnt < MAX_CNT);
            sel0 = !sel1;
        end else if (m0_req && m1_req) begin
            sel0 = last;
            sel1 = !last;
        end else begin
            sel0 = m0_req;
            sel1 = m1_req;
        end
    end
    assign m0_gnt   = sel0 & ~rst;
    assign m1_gnt   = sel1 & ~rst;
    assign mem_en   = m0_gnt | m1_gnt;
    assign mem_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
    assign mem_d    = m0_gnt ? m0_d    : m1_gnt ? m1_d    : '0;
    assign mem_we   = m0_gnt ? m0_we   : m1_gnt ? m1_we   : '0;
    // lock holds while port 1 keeps req and lock; burst count only tracks grants that make port 0 wait
    always_comb begin
        locked_nxt = (m1_gnt & m1_lock) | (locked & m1_req & m1_lock);
        burst_nxt  = burst_cnt;
        if (m1_gnt && (locked || m1_lock) && m0_req)
            burst_nxt = (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
        if (m0_gnt || !m0_req || !m1_req || !m1_lock)
            burst_nxt = '0;
    end
    // arbitration state and response ownership; reset drops any in-flight response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b1;
            locked    <= 1'b0;
            burst_cnt <= '0;
            r_owner0  <= 1'b0;
            r_owner1  <= 1'b0;
        end else begin
            last      <= m1_gnt ? 1'b1 : m0_gnt ? 1'b0 : last;
            locked    <= locked_nxt;
            burst_cnt <= burst_nxt;
            r_owner0  <= m0_gnt;
            r_owner1  <= m1_gnt;
        end
    end
    assign m0_rvalid = r_owner0;
    assign m1_rvalid = r_owner1;
    assign m0_rdata  = r_owner0 ? mem_q : '0;
    assign m1_rdata  = r_owner1 ? mem_q : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a response scoreboard and a simple memory model
module tb_dmem_arbiter;
    logic        clk;
    logic        rst;
    logic        m0_req, m1_req, m1_lock;
    logic [31:0] m0_addr, m0_d, m1_addr, m1_d;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en;
    logic [31:0] mem_addr, mem_d, mem_q;
    logic [3:0]  mem_we;
    int          total;
    int          bad;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] d;
    } resp_t;
    resp_t q[$];

    dmem_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_d(m0_d), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_d(m1_d), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // memory model: word read one cycle after enable
    always @(posedge clk) if (mem_en) mem_q <= f(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic e0, input logic e1);
        resp_t r;
        #1;
        chk("m0_gnt", 32'(m0_gnt), 32'(e0));
        chk("m1_gnt", 32'(m1_gnt), 32'(e1));
        chk("mem_en", 32'(mem_en), 32'(e0 | e1));
        chk("mem_addr", mem_addr, e0 ? m0_addr : e1 ? m1_addr : 32'h0);
        chk("mem_d", mem_d, e0 ? m0_d : e1 ? m1_d : 32'h0);
        chk("mem_we", 32'(mem_we), 32'(e0 ? m0_we : e1 ? m1_we : 4'h0));
        r.v0 = e0;
        r.v1 = e1;
        r.d  = e0 ? f(m0_addr) : e1 ? f(m1_addr) : 32'h0;
        q.push_back(r);
        @(posedge clk);
        #1;
        r = q.pop_front();
        chk("m0_rvalid", 32'(m0_rvalid), 32'(r.v0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(r.v1));
        chk("m0_rdata", m0_rdata, r.v0 ? r.d : 32'h0);
        chk("m1_rdata", m1_rdata, r.v1 ? r.d : 32'h0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        mem_q = 32'h0;
        rst = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1;
        m0_addr = 32'h10; m1_addr = 32'h20; m0_d = 32'h1111_1111; m1_d = 32'h2222_2222;
        m0_we = 4'hF; m1_we = 4'hF;
        @(posedge clk);
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_d", mem_d, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_we = 4'h0; m1_we = 4'h0;
        rst = 1'b0;
        // single m0 read
        m0_req = 1'b1; m0_addr = 32'h0080_0010;
        cyc(1'b1, 1'b0);
        m0_req = 1'b0;
        cyc(1'b0, 1'b0);
        // round-robin, last grant was m0 so m1 leads
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            cyc((i % 2) == 1, (i % 2) == 0);
            if ((i % 2) == 1) m0_addr = m0_addr + 32'h4;
            else m1_addr = m1_addr + 32'h4;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        cyc(1'b0, 1'b0);
        // locked burst with m0 waiting: four m1 grants, one forced m0 grant, repeat
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h300;
        cyc(1'b0, 1'b1);
        m0_req = 1'b1; m0_addr = 32'h400;
        for (int k = 0; k < 10; k++) begin
            m1_addr = m1_addr + 32'h4;
            cyc((k % 5) == 4, (k % 5) != 4);
            if ((k % 5) == 4) m0_addr = m0_addr + 32'h4;
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        cyc(1'b0, 1'b0);
        // locked burst with m0 idle, then m0 arrives and waits at most the burst limit
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h700; m0_addr = 32'h800;
        for (int k = 0; k < 15; k++) begin
            if (k == 10) m0_req = 1'b1;
            m1_addr = m1_addr + 32'h4;
            cyc(k == 14, k != 14);
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        cyc(1'b0, 1'b0);
        // byte write
        m0_req = 1'b1; m0_we = 4'b0100; m0_d = 32'hAABB_CCDD; m0_addr = 32'h0080_0020;
        cyc(1'b1, 1'b0);
        m0_req = 1'b0; m0_we = 4'h0;
        cyc(1'b0, 1'b0);
        // reset during an m1 access
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h500;
        #1;
        chk("pre_rst_m1_gnt", 32'(m1_gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("in_rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("in_rst_mem_en", 32'(mem_en), 32'h0);
        chk("in_rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("post_rst_m1_rdata", m1_rdata, 32'h0);
        rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h600;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
        cyc(1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
